// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch front end for the instruction decoder. Holds the PC, issues reads
//   to a sync-read instruction memory and hands the returned 32-bit words to
//   the decoder over a valid/ready pair. The decoder's jump/halt verdict for
//   the word being transferred redirects or stops the fetch stream.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, start_addr          begin fetching at start_addr (IDLE/HALT only)
//   imem_en, imem_addr         read strobe / address, data returns next cycle
//   imem_rdata                 read data, valid the cycle after imem_en
//   ins, ins_pc, ins_valid     instruction word, its address, live flag
//   ins_ready                  decoder accepts ins this cycle
//   dec_isJump, dec_jumpAddr   decoder redirect for the word on ins
//   dec_isHalted               decoder halt flag for the word on ins
//   halted, busy               HALT / RUN state indicators
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | out of reset, no fetching, waiting for start
// RUN   | fetching and presenting words to the decoder
// HALT  | decoder accepted a halting word, fetch stopped until start
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int                 ADDR_W   = 10,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       ins,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   input  logic              dec_isJump,
   input  logic [ADDR_W-1:0] dec_jumpAddr,
   input  logic              dec_isHalted,
   output logic              halted,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;

   // read issued last cycle whose data is on imem_rdata now
   logic              rd_vld, rd_vld_nxt;
   logic [ADDR_W-1:0] rd_pc, rd_pc_nxt;

   // output register (head of queue) and skid register behind it
   logic              out_vld, out_vld_nxt;
   logic [31:0]       out_ins, out_ins_nxt;
   logic [ADDR_W-1:0] out_pc, out_pc_nxt;
   logic              skid_vld, skid_vld_nxt;
   logic [31:0]       skid_ins, skid_ins_nxt;
   logic [ADDR_W-1:0] skid_pc, skid_pc_nxt;

   logic              xfer;
   logic              redirect;
   logic [1:0]        occ;
   logic [1:0]        occ_after;
   logic              room;

   // The returning read is presented straight from imem_rdata when nothing
   // older is held, which is what gives the two-cycle start/jump latency.
   always_comb begin
      ins       = '0;
      ins_pc    = '0;
      ins_valid = out_vld | rd_vld;
      if (out_vld) begin
         ins    = out_ins;
         ins_pc = out_pc;
      end else if (rd_vld) begin
         ins    = imem_rdata;
         ins_pc = rd_pc;
      end
   end

   assign xfer     = ins_valid & ins_ready;
   assign redirect = xfer & (dec_isJump | dec_isHalted);

   // A new read is allowed only if, after this cycle's transfer, at most one
   // word is left waiting; the new word then always has a register to land in.
   assign occ       = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld};
   assign occ_after = occ - {1'b0, xfer};
   assign room      = (occ_after <= 2'd1);

   assign imem_en   = (state == RUN) & room;
   assign imem_addr = pc;
   assign halted    = (state == HALT);
   assign busy      = (state == RUN);

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      rd_vld_nxt   = 1'b0;
      rd_pc_nxt    = pc;
      out_vld_nxt  = out_vld;
      out_ins_nxt  = out_ins;
      out_pc_nxt   = out_pc;
      skid_vld_nxt = skid_vld;
      skid_ins_nxt = skid_ins;
      skid_pc_nxt  = skid_pc;

      case (state)
         IDLE, HALT: begin
            out_vld_nxt  = 1'b0;
            skid_vld_nxt = 1'b0;
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = start_addr;
            end
         end

         RUN: begin
            if (imem_en) begin
               pc_nxt     = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
               rd_vld_nxt = 1'b1;
               rd_pc_nxt  = pc;
            end

            if (out_vld) begin
               if (xfer) begin
                  if (skid_vld) begin
                     out_ins_nxt  = skid_ins;
                     out_pc_nxt   = skid_pc;
                     skid_vld_nxt = rd_vld;
                     skid_ins_nxt = imem_rdata;
                     skid_pc_nxt  = rd_pc;
                  end else begin
                     out_vld_nxt  = rd_vld;
                     out_ins_nxt  = imem_rdata;
                     out_pc_nxt   = rd_pc;
                  end
               end else if (!skid_vld) begin
                  skid_vld_nxt = rd_vld;
                  skid_ins_nxt = imem_rdata;
                  skid_pc_nxt  = rd_pc;
               end
            end else begin
               // head was the bypassed read; keep it only if not taken
               out_vld_nxt = rd_vld & ~xfer;
               out_ins_nxt = imem_rdata;
               out_pc_nxt  = rd_pc;
            end

            // redirect squashes everything younger than the transferred word,
            // including a read issued in this same cycle
            if (redirect) begin
               out_vld_nxt  = 1'b0;
               skid_vld_nxt = 1'b0;
               rd_vld_nxt   = 1'b0;
               if (dec_isJump) begin
                  pc_nxt = dec_jumpAddr;
               end else begin
                  pc_nxt = pc;
               end
               if (dec_isHalted) begin
                  state_nxt = HALT;
               end
            end
         end

         default: begin
            state_nxt    = IDLE;
            out_vld_nxt  = 1'b0;
            skid_vld_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         rd_vld   <= 1'b0;
         rd_pc    <= '0;
         out_vld  <= 1'b0;
         out_ins  <= '0;
         out_pc   <= '0;
         skid_vld <= 1'b0;
         skid_ins <= '0;
         skid_pc  <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         rd_vld   <= rd_vld_nxt;
         rd_pc    <= rd_pc_nxt;
         out_vld  <= out_vld_nxt;
         out_ins  <= out_ins_nxt;
         out_pc   <= out_pc_nxt;
         skid_vld <= skid_vld_nxt;
         skid_ins <= skid_ins_nxt;
         skid_pc  <= skid_pc_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch: sync-read memory model returning
//   a word derived from its address, and a stub decoder that flags a jump or
//   a halt at chosen addresses.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata = '0;
   logic [31:0]       ins;
   logic [ADDR_W-1:0] ins_pc;
   logic              ins_valid;
   logic              ins_ready;
   logic              dec_isJump;
   logic [ADDR_W-1:0] dec_jumpAddr;
   logic              dec_isHalted;
   logic              halted;
   logic              busy;

   logic [ADDR_W-1:0] jump_pc  = 10'h014;
   logic [ADDR_W-1:0] jump_tgt = 10'h200;
   logic [ADDR_W-1:0] halt_pc  = 10'h020;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(10'h000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_addr   (start_addr),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .ins          (ins),
      .ins_pc       (ins_pc),
      .ins_valid    (ins_valid),
      .ins_ready    (ins_ready),
      .dec_isJump   (dec_isJump),
      .dec_jumpAddr (dec_jumpAddr),
      .dec_isHalted (dec_isHalted),
      .halted       (halted),
      .busy         (busy)
   );

   function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
      return {8'hA5, 14'h0000, a};
   endfunction

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= word_of(imem_addr);
   end

   assign dec_isJump   = ins_valid && (ins_pc == jump_pc);
   assign dec_jumpAddr = jump_tgt;
   assign dec_isHalted = ins_valid && (ins_pc == halt_pc);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [ADDR_W-1:0] a);
      tick();
      start      = 1'b1;
      start_addr = a;
      tick();
      start      = 1'b0;
   endtask

   task automatic expect_seq(input logic [ADDR_W-1:0] base, input int n);
      logic [ADDR_W-1:0] e;
      for (int i = 0; i < n; i++) begin
         tick();
         #1;
         e = base + ADDR_W'(i);
         chk("seq_valid", 32'(ins_valid), 32'd1);
         chk("seq_pc",    32'(ins_pc),    32'(e));
         chk("seq_ins",   ins,            word_of(e));
      end
   endtask

   task automatic expect_halted(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         #1;
         chk("hlt_halted", 32'(halted),    32'd1);
         chk("hlt_busy",   32'(busy),      32'd0);
         chk("hlt_imem_en",32'(imem_en),   32'd0);
         chk("hlt_valid",  32'(ins_valid), 32'd0);
      end
   endtask

   initial begin
      logic              pat [20];
      logic [ADDR_W-1:0] exp_pc;
      logic [31:0]       held_ins;
      logic [ADDR_W-1:0] held_pc;
      logic              stalled;
      int                acc;

      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_n      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      ins_ready  = 1'b0;
      #12;
      chk("rst_valid",   32'(ins_valid), 32'd0);
      chk("rst_imem_en", 32'(imem_en),   32'd0);
      chk("rst_addr",    32'(imem_addr), 32'h000);
      chk("rst_ins",     ins,            32'h0);
      chk("rst_halted",  32'(halted),    32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      rst_n = 1'b1;

      // start at 0x010 with ready held high
      ins_ready = 1'b1;
      start_run(10'h010);
      #1;
      chk("st_busy",    32'(busy),      32'd1);
      chk("st_imem_en", 32'(imem_en),   32'd1);
      chk("st_addr",    32'(imem_addr), 32'h010);
      chk("st_valid",   32'(ins_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("str_valid", 32'(ins_valid), 32'd1);
         chk("str_pc",    32'(ins_pc),    32'h010 + 32'(i));
         chk("str_lead",  32'(imem_addr), 32'h011 + 32'(i));
      end

      // jump at 0x014 -> 0x200 with exactly one bubble
      tick();
      #1;
      chk("jmp_pc",       32'(ins_pc),    32'h014);
      chk("jmp_valid",    32'(ins_valid), 32'd1);
      tick();
      #1;
      chk("bub_valid",    32'(ins_valid), 32'd0);
      chk("bub_imem_en",  32'(imem_en),   32'd1);
      chk("bub_addr",     32'(imem_addr), 32'h200);

      // toggled ready stream starting at the jump target
      exp_pc  = 10'h200;
      stalled = 1'b0;
      held_ins = '0;
      held_pc  = '0;
      acc      = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ins_ready = pat[i];
         #1;
         if (stalled) begin
            chk("stall_valid", 32'(ins_valid), 32'd1);
            chk("stall_ins",   ins,            held_ins);
            chk("stall_pc",    32'(ins_pc),    32'(held_pc));
         end
         if (ins_valid && ins_ready) begin
            chk("acc_pc",  32'(ins_pc), 32'(exp_pc));
            chk("acc_ins", ins,         word_of(exp_pc));
            exp_pc = exp_pc + 10'h001;
            acc++;
         end
         stalled  = ins_valid && !ins_ready;
         held_ins = ins;
         held_pc  = ins_pc;
      end
      chk("acc_cnt", 32'(acc), 32'd9);

      // reset while stalled with a live word
      tick();
      #1;
      chk("pre_rst_valid", 32'(ins_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid",   32'(ins_valid), 32'd0);
      chk("mrst_imem_en", 32'(imem_en),   32'd0);
      chk("mrst_addr",    32'(imem_addr), 32'h000);
      chk("mrst_busy",    32'(busy),      32'd0);
      chk("mrst_halted",  32'(halted),    32'd0);
      #3;
      rst_n     = 1'b1;
      ins_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("idle_valid",   32'(ins_valid), 32'd0);
         chk("idle_imem_en", 32'(imem_en),   32'd0);
      end

      // halt at 0x020, then restart at 0x000 (halting again at 0x003)
      start_run(10'h01C);
      expect_seq(10'h01C, 5);
      expect_halted(3);
      halt_pc = 10'h003;
      start_run(10'h000);
      expect_seq(10'h000, 4);
      expect_halted(2);

      // PC wrap from the top of the address space
      halt_pc = 10'h002;
      start_run(10'h3FE);
      expect_seq(10'h3FE, 5);
      expect_halted(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
